d3s_frev_timestamper: RTL and testbench
=======================================

# d3s_frev_timestamper

Transmit side of the D3S revolution-frequency timestamp path: watches the divided, 4-sub-sample-per-cycle RF phase stream and emits one White Rabbit TAI/ns timestamp per detected revolution tick (forward phase wrap). Its output pulses are the `frev_ts_*` producer that the receiving node's upsample/divide block consumes to align its divider. It sits after the divider in the ADC-side node and feeds the WR streamer framing logic through a one-deep valid/ready holding register.

## Interface
- `g_adjust_ns`, 0: constant added to every timestamp (cable/pipeline compensation); legal range 0..999999999.
- `g_ns_per_cycle`, 8: ns per `clk_i` cycle; each sub-sample spans `g_ns_per_cycle/4` ns.
- `g_holdoff_cycles`, 16: cycles after an accepted tick during which further wraps are ignored (deglitch).
- `clk_i` in 1: WR reference clock (125 MHz). Single clock domain.
- `rst_i` in 1: synchronous reset, active high.
- `phase_i` in 56: four 14-bit wrapped phases, sub-sample k at bits [14k+13:14k], k=0 earliest.
- `phase_valid_i` in 1: `phase_i` valid this cycle.
- `enable_i` in 1: level; 0 forces IDLE.
- `tm_time_valid_i` in 1: WR time valid.
- `tm_tai_i` in 32: current TAI seconds.
- `tm_cycles_i` in 28: current cycle count within second (0..124999999).
- `frev_ts_tai_o` out 32: timestamp seconds.
- `frev_ts_nsec_o` out 32: timestamp ns (0..999999999).
- `frev_ts_valid_o` out 1: timestamp available; held until accepted.
- `frev_ts_ready_i` in 1: consumer accepts when high with valid.
- `overflow_o` out 1: sticky; a tick was dropped because the holding register was full.
- `ts_count_o` out 32: accepted-tick counter (wraps at 2^32).

## Operation
- States: IDLE, SEED, RUN, HOLDOFF.
  - IDLE: entered on reset or whenever `enable_i`=0 or `tm_time_valid_i`=0 (from any state, same cycle). Leaves to SEED when both high.
  - SEED: first valid word stored as history (`prev` = sub-sample 3); no detection on it; → RUN.
  - RUN: each valid word, sub-sample k wraps iff `prev_k − cur_k` (14-bit, unsigned) ≥ 8192 and `prev_k > cur_k`, where `prev_0` = sub-sample 3 of previous valid word, `prev_k` = sub-sample k−1 otherwise. Lowest wrapping k is the tick; others in the word ignored. On tick → HOLDOFF, counter loaded with `g_holdoff_cycles`.
  - HOLDOFF: decrements every cycle (valid or not); history still updated; wraps ignored; at 0 → RUN.
  - Invalid cycles (`phase_valid_i`=0) neither update history nor detect.
- Timestamp: `tm_tai_i`/`tm_cycles_i` registered with the word; ns = cycles·`g_ns_per_cycle` + k·`g_ns_per_cycle`/4 + `g_adjust_ns`; if ≥ 10^9: subtract 10^9, TAI+1. Arithmetic in 32 bits, no overflow for legal params.
- Holding register: loaded when empty, or when `frev_ts_ready_i`=1 in the same cycle (simultaneous accept-and-load allowed). Full and not accepted → tick dropped, `overflow_o`←1; FSM still enters HOLDOFF.
- `ts_count_o` increments on each handshake (valid & ready).
- Entering IDLE does not clear a pending holding register or `overflow_o`; only `rst_i` does.

## Timing
- Reset: all outputs 0, state IDLE, history cleared.
- Latency: word sampled at edge E → `frev_ts_valid_o` high after edge E+2 (stage 1 detect/select k, stage 2 adjust/load).
- Valid stays high, data stable, until the edge where `frev_ts_ready_i`=1; deasserts next cycle unless reloaded.
- `tm_cycles_i` wrap (124999999→0) is handled purely by the registered sample; no special case.
- `rst_i` mid-pipeline discards in-flight ticks.

## Test plan
- Seed: enable, words with sub-sample 3 = 16000, next word {200, 600, 1000, 1400} at `tm_cycles_i`=1000, ready=1 → one pulse, nsec=8000, TAI unchanged, `ts_count_o`=1, valid 2 cycles after word.
- Mid-word: word {15000,15500,100,500} following prev 14500, cycles=2000 → nsec=16004; only one tick.
- Rollover: `g_adjust_ns`=5000, cycles=124999999, wrap at k=3, TAI=7 → TAI=8, nsec=4998.
- Holdoff/glitch: wrap, then backward jitter 100→16300→100 within 10 cycles → exactly one tick; phase 3000→2900 (small decrease) → no tick.
- Backpressure: ready=0, two ticks 40 cycles apart → first timestamp held stable, second dropped, `overflow_o`=1; ready=1 → one handshake, `ts_count_o`=1.
- Reset/disable: `tm_time_valid_i`→0 mid-stream then back → SEED word produces no tick; `rst_i` one cycle after a word with a tick → no valid, all outputs 0.

Source files
------------

// File: rtl/d3s_frev_timestamper.sv
// D3S revolution-tick timestamper: finds forward phase wraps in the 4-sub-sample
// RF phase stream and emits one WR TAI/ns timestamp per tick through a 1-deep register.

module d3s_frev_wrap_lane #(
  parameter int VEC_W = 14
) (
  input  logic [VEC_W-1:0] prev,
  input  logic [VEC_W-1:0] cur,
  output logic             wrap
);
  logic [VEC_W-1:0] diff;

  // Forward wrap: modular step of at least half a turn, with an actual numeric drop.
  assign diff = prev - cur;
  assign wrap = diff[VEC_W-1] && (prev > cur);
endmodule

module d3s_frev_timestamper #(
  parameter int unsigned g_adjust_ns      = 0,
  parameter int unsigned g_ns_per_cycle   = 8,
  parameter int unsigned g_holdoff_cycles = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [55:0] phase_i,
  input  logic        phase_valid_i,
  input  logic        enable_i,
  input  logic        tm_time_valid_i,
  input  logic [31:0] tm_tai_i,
  input  logic [27:0] tm_cycles_i,
  output logic [31:0] frev_ts_tai_o,
  output logic [31:0] frev_ts_nsec_o,
  output logic        frev_ts_valid_o,
  input  logic        frev_ts_ready_i,
  output logic        overflow_o,
  output logic [31:0] ts_count_o
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 14;
  localparam int STAGES    = 1;
  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

  typedef enum logic [1:0] {IDLE, SEED, RUN, HOLDOFF} state_t;

  typedef struct packed {
    logic [31:0] tai;
    logic [27:0] cycles;
    logic [1:0]  k;
  } det_t;

  typedef struct packed {
    logic [31:0] tai;
    logic [31:0] nsec;
  } ts_t;

  state_t state_q, state_d;
  logic [31:0] ho_cnt_q, ho_cnt_d;
  logic [VEC_W-1:0] hist_q;
  logic hist_upd, tick;

  logic [NUM_LANES-1:0][VEC_W-1:0] cur, prv;
  logic [NUM_LANES-1:0]            wrap;
  logic [1:0]                      tick_k;

  det_t det_q;
  ts_t  adj_q, hold_q;
  logic [STAGES:0] vld_pipe;
  logic [31:0] ns_raw;
  logic        ns_carry;
  logic        hold_vld_q, ovf_q, hs, load;
  logic [31:0] cnt_q;

  // Lane k compares against the sample just before it; lane 0 reaches back to the last word.
  assign cur = phase_i;
  assign prv = {cur[NUM_LANES-2:0], hist_q};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    d3s_frev_wrap_lane #(.VEC_W(VEC_W)) u_lane (
      .prev (prv[k]),
      .cur  (cur[k]),
      .wrap (wrap[k])
    );
  end

  always_comb begin
    tick_k = '0;
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (wrap[i]) tick_k = 2'(i);
  end

  always_comb begin
    state_d  = state_q;
    ho_cnt_d = ho_cnt_q;
    hist_upd = 1'b0;
    tick     = 1'b0;
    if (!(enable_i && tm_time_valid_i)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = SEED;
        SEED: if (phase_valid_i) begin
          hist_upd = 1'b1;
          state_d  = RUN;
        end
        RUN: if (phase_valid_i) begin
          hist_upd = 1'b1;
          if (|wrap) begin
            tick     = 1'b1;
            state_d  = HOLDOFF;
            ho_cnt_d = 32'(g_holdoff_cycles);
          end
        end
        HOLDOFF: begin
          hist_upd = phase_valid_i;
          if (ho_cnt_q == '0) state_d = RUN;
          else ho_cnt_d = ho_cnt_q - 32'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ho_cnt_q <= '0;
      hist_q   <= '0;
    end else begin
      state_q  <= state_d;
      ho_cnt_q <= ho_cnt_d;
      if (hist_upd) hist_q <= cur[NUM_LANES-1];
    end
  end

  // Stage 2 arithmetic: ns within the second, folded once into the next TAI second.
  assign ns_raw = 32'(det_q.cycles) * 32'(g_ns_per_cycle)
                + (32'(det_q.k) * 32'(g_ns_per_cycle)) / 32'd4
                + 32'(g_adjust_ns);
  assign ns_carry = (ns_raw >= NS_PER_SEC);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      det_q    <= '0;
      adj_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], tick};
      if (tick) det_q <= '{tai: tm_tai_i, cycles: tm_cycles_i, k: tick_k};
      if (vld_pipe[0]) begin
        adj_q.tai  <= det_q.tai + 32'(ns_carry);
        adj_q.nsec <= ns_carry ? (ns_raw - NS_PER_SEC) : ns_raw;
      end
    end
  end

  assign hs   = hold_vld_q && frev_ts_ready_i;
  assign load = vld_pipe[STAGES] && (!hold_vld_q || frev_ts_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (load) begin
        hold_q     <= adj_q;
        hold_vld_q <= 1'b1;
      end else if (hs) begin
        hold_vld_q <= 1'b0;
      end
      if (vld_pipe[STAGES] && hold_vld_q && !frev_ts_ready_i) ovf_q <= 1'b1;
      if (hs) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign frev_ts_tai_o   = hold_q.tai;
  assign frev_ts_nsec_o  = hold_q.nsec;
  assign frev_ts_valid_o = hold_vld_q;
  assign overflow_o      = ovf_q;
  assign ts_count_o      = cnt_q;
endmodule

// File: tb/tb_d3s_frev_timestamper.sv
// Scenario bench for d3s_frev_timestamper; expected timestamps queued at stimulus, popped on handshake.

module tb_d3s_frev_timestamper;
  localparam int unsigned ADJ = 5000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [55:0] phase_i;
  logic        phase_valid_i;
  logic        enable_i;
  logic        tm_time_valid_i;
  logic [31:0] tm_tai_i;
  logic [27:0] tm_cycles_i;
  logic [31:0] frev_ts_tai_o;
  logic [31:0] frev_ts_nsec_o;
  logic        frev_ts_valid_o;
  logic        frev_ts_ready_i;
  logic        overflow_o;
  logic [31:0] ts_count_o;

  always #5 clk = ~clk;

  d3s_frev_timestamper #(
    .g_adjust_ns      (ADJ),
    .g_ns_per_cycle   (8),
    .g_holdoff_cycles (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .phase_i         (phase_i),
    .phase_valid_i   (phase_valid_i),
    .enable_i        (enable_i),
    .tm_time_valid_i (tm_time_valid_i),
    .tm_tai_i        (tm_tai_i),
    .tm_cycles_i     (tm_cycles_i),
    .frev_ts_tai_o   (frev_ts_tai_o),
    .frev_ts_nsec_o  (frev_ts_nsec_o),
    .frev_ts_valid_o (frev_ts_valid_o),
    .frev_ts_ready_i (frev_ts_ready_i),
    .overflow_o      (overflow_o),
    .ts_count_o      (ts_count_o)
  );

  typedef struct {
    logic [31:0] tai;
    logic [31:0] nsec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_mis = 0;

  // Every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_i && frev_ts_valid_o && frev_ts_ready_i) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_ts: got tai=%0d nsec=%0d, expected no timestamp", frev_ts_tai_o, frev_ts_nsec_o);
      end else begin
        mon_e = sb.pop_front();
        if (frev_ts_tai_o !== mon_e.tai || frev_ts_nsec_o !== mon_e.nsec) begin
          n_mis++;
          $display("FAIL ts_value: got tai=%0d nsec=%0d, expected tai=%0d nsec=%0d",
                   frev_ts_tai_o, frev_ts_nsec_o, mon_e.tai, mon_e.nsec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic word(input logic [13:0] s0, input logic [13:0] s1, input logic [13:0] s2,
                      input logic [13:0] s3, input logic [27:0] cyc, input logic [31:0] tai);
    phase_i       = {s3, s2, s1, s0};
    tm_cycles_i   = cyc;
    tm_tai_i      = tai;
    phase_valid_i = 1'b1;
    step();
    phase_valid_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] tai, input logic [31:0] nsec);
    exp_t e;
    e.tai  = tai;
    e.nsec = nsec;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle(3);
    @(negedge clk);
    n_cmp++; if (frev_ts_valid_o !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %0b, expected 0", frev_ts_valid_o); end
    n_cmp++; if (frev_ts_tai_o !== 32'd0) begin n_mis++; $display("FAIL reset_tai: got %0d, expected 0", frev_ts_tai_o); end
    n_cmp++; if (frev_ts_nsec_o !== 32'd0) begin n_mis++; $display("FAIL reset_nsec: got %0d, expected 0", frev_ts_nsec_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_mis++; $display("FAIL reset_overflow: got %0b, expected 0", overflow_o); end
    n_cmp++; if (ts_count_o !== 32'd0) begin n_mis++; $display("FAIL reset_count: got %0d, expected 0", ts_count_o); end
    step();
    rst_i = 1'b0;
    idle(2);
  endtask

  task automatic test_seed();
    enable_i        = 1'b1;
    tm_time_valid_i = 1'b1;
    step();
    word(14'd0, 14'd0, 14'd0, 14'd16000, 28'd900, 32'd5);
    push(32'd5, 32'd8000 + ADJ);
    word(14'd200, 14'd600, 14'd1000, 14'd1400, 28'd1000, 32'd5);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (frev_ts_valid_o !== 1'b0) begin n_mis++; $display("FAIL seed_latency_early: got valid=%0b, expected 0", frev_ts_valid_o); end
    @(negedge clk);
    n_cmp++; if (frev_ts_valid_o !== 1'b1) begin n_mis++; $display("FAIL seed_latency: got valid=%0b, expected 1", frev_ts_valid_o); end
    idle(3);
    n_cmp++; if (ts_count_o !== 32'd1) begin n_mis++; $display("FAIL seed_count: got %0d, expected 1", ts_count_o); end
    idle(20);
  endtask

  task automatic test_midword();
    word(14'd14000, 14'd14200, 14'd14300, 14'd14500, 28'd1900, 32'd5);
    push(32'd5, 32'd16004 + ADJ);
    word(14'd15000, 14'd15500, 14'd100, 14'd500, 28'd2000, 32'd5);
    idle(6);
    n_cmp++; if (ts_count_o !== 32'd2) begin n_mis++; $display("FAIL midword_count: got %0d, expected 2", ts_count_o); end
    idle(20);
  endtask

  task automatic test_rollover();
    word(14'd1000, 14'd4000, 14'd8000, 14'd12000, 28'd124999998, 32'd7);
    push(32'd8, 32'd4998);
    word(14'd13000, 14'd14000, 14'd15000, 14'd50, 28'd124999999, 32'd7);
    idle(6);
    n_cmp++; if (ts_count_o !== 32'd3) begin n_mis++; $display("FAIL rollover_count: got %0d, expected 3", ts_count_o); end
    idle(20);
  endtask

  task automatic test_holdoff();
    word(14'd16000, 14'd16100, 14'd16200, 14'd16300, 28'd3000, 32'd5);
    push(32'd5, 32'd24008 + ADJ);
    word(14'd100, 14'd16300, 14'd100, 14'd200, 28'd3001, 32'd5);
    idle(2);
    word(14'd16300, 14'd100, 14'd16300, 14'd100, 28'd3004, 32'd5);
    idle(25);
    word(14'd3000, 14'd3000, 14'd3000, 14'd3000, 28'd4000, 32'd5);
    word(14'd2900, 14'd2900, 14'd2900, 14'd2900, 28'd4001, 32'd5);
    idle(6);
    n_cmp++; if (ts_count_o !== 32'd4) begin n_mis++; $display("FAIL holdoff_count: got %0d, expected 4", ts_count_o); end
    n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL holdoff_pending: got %0d outstanding, expected 0", sb.size()); end
    idle(20);
  endtask

  task automatic test_backpressure();
    logic stable;
    frev_ts_ready_i = 1'b0;
    word(14'd16000, 14'd16100, 14'd16200, 14'd16300, 28'd5000, 32'd5);
    push(32'd5, 32'd40008 + ADJ);
    word(14'd10, 14'd20, 14'd30, 14'd40, 28'd5001, 32'd5);
    repeat (3) @(negedge clk);
    n_cmp++; if (frev_ts_valid_o !== 1'b1) begin n_mis++; $display("FAIL bp_valid: got %0b, expected 1", frev_ts_valid_o); end
    stable = 1'b1;
    repeat (36) begin
      @(negedge clk);
      if (frev_ts_valid_o !== 1'b1 || frev_ts_nsec_o !== 32'd40008 + ADJ || frev_ts_tai_o !== 32'd5) stable = 1'b0;
    end
    n_cmp++; if (stable !== 1'b1) begin n_mis++; $display("FAIL bp_stable: got stable=%0b, expected 1", stable); end
    word(14'd16000, 14'd16100, 14'd16200, 14'd16300, 28'd5040, 32'd5);
    word(14'd10, 14'd20, 14'd30, 14'd40, 28'd5041, 32'd5);
    repeat (4) @(negedge clk);
    n_cmp++; if (overflow_o !== 1'b1) begin n_mis++; $display("FAIL bp_overflow: got %0b, expected 1", overflow_o); end
    n_cmp++; if (frev_ts_nsec_o !== 32'd40008 + ADJ) begin n_mis++; $display("FAIL bp_held: got nsec=%0d, expected %0d", frev_ts_nsec_o, 40008 + ADJ); end
    step();
    frev_ts_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (frev_ts_valid_o !== 1'b0) begin n_mis++; $display("FAIL bp_drain: got valid=%0b, expected 0", frev_ts_valid_o); end
    n_cmp++; if (ts_count_o !== 32'd5) begin n_mis++; $display("FAIL bp_count: got %0d, expected 5", ts_count_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_mis++; $display("FAIL bp_sticky: got %0b, expected 1", overflow_o); end
    idle(20);
  endtask

  task automatic test_disable();
    word(14'd12000, 14'd13000, 14'd14000, 14'd15000, 28'd6000, 32'd5);
    tm_time_valid_i = 1'b0;
    step();
    tm_time_valid_i = 1'b1;
    step();
    word(14'd100, 14'd200, 14'd300, 14'd400, 28'd6010, 32'd5);
    word(14'd500, 14'd600, 14'd700, 14'd800, 28'd6011, 32'd5);
    idle(6);
    n_cmp++; if (ts_count_o !== 32'd5) begin n_mis++; $display("FAIL disable_count: got %0d, expected 5", ts_count_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_mis++; $display("FAIL disable_overflow: got %0b, expected 1", overflow_o); end
  endtask

  task automatic test_rst_mid();
    word(14'd12000, 14'd13000, 14'd14000, 14'd15000, 28'd7000, 32'd5);
    word(14'd5, 14'd6, 14'd7, 14'd8, 28'd7001, 32'd5);
    rst_i = 1'b1;
    idle(2);
    @(negedge clk);
    n_cmp++; if (overflow_o !== 1'b0) begin n_mis++; $display("FAIL rst_overflow: got %0b, expected 0", overflow_o); end
    n_cmp++; if (ts_count_o !== 32'd0) begin n_mis++; $display("FAIL rst_count: got %0d, expected 0", ts_count_o); end
    step();
    rst_i = 1'b0;
    idle(6);
    n_cmp++; if (frev_ts_valid_o !== 1'b0) begin n_mis++; $display("FAIL rst_inflight: got valid=%0b, expected 0", frev_ts_valid_o); end
    n_cmp++; if (frev_ts_tai_o !== 32'd0 || frev_ts_nsec_o !== 32'd0) begin
      n_mis++; $display("FAIL rst_data: got tai=%0d nsec=%0d, expected 0/0", frev_ts_tai_o, frev_ts_nsec_o);
    end
  endtask

  initial begin
    rst_i           = 1'b1;
    phase_i         = '0;
    phase_valid_i   = 1'b0;
    enable_i        = 1'b0;
    tm_time_valid_i = 1'b0;
    tm_tai_i        = 32'd5;
    tm_cycles_i     = '0;
    frev_ts_ready_i = 1'b1;
    test_reset();
    test_seed();
    test_midword();
    test_rollover();
    test_holdoff();
    test_backpressure();
    test_disable();
    test_rst_mid();
    n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL scoreboard_empty: got %0d outstanding, expected 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
